polymul_feeder: RTL

Front-end sequencer for pointwise polynomial multiplication in the NTT datapath. Walks both operand memories in lockstep and multiplies each coefficient pair with a registered unsigned multiplier. Drives the 32-bit product plus `load`/`en` qualifiers straight into the Montgomery reduction stage, which consumes them without glue logic. One `start` pulse processes N coefficient pairs, then pulses `done`.

---
 rtl/polymul_feeder.sv | 111 +++++++++++
 1 files changed

// File: rtl/polymul_feeder.sv
// Pointwise-multiply feeder: walks both operand memories in lockstep and emits registered products.
// Optional operand range check is enabled by defining POLYMUL_RANGE_CHECK_EN.
module polymul_feeder #(
  parameter int N      = 1024,
  parameter int ADDR_W = 10,
  parameter int Q      = 12289
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [15:0]       a_data,
  input  logic [15:0]       b_data,
  output logic [31:0]       prod,
  output logic              prod_load,
  output logic              prod_en,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                drn_q, drn_d;
  logic                rd_q;
  logic [31:0]         prod_q;
  logic                load_q;

  // IDLE->RUN and DONE->IDLE ignore en so start/done are never lost to a stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        drn_d   = 1'b0;
      end
      RUN: if (en) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(N-1)) state_d = DRAIN;
      end
      DRAIN: if (en) begin
        drn_d = ~drn_q;
        if (drn_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state_q == RUN) && en;
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
  end

  // Read strobe -> data capture -> product, all frozen while en is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q   <= 1'b0;
      prod_q <= '0;
      load_q <= 1'b0;
    end else if (en) begin
      rd_q   <= rd_en;
      load_q <= rd_q;
      if (rd_q) prod_q <= 32'(a_data) * 32'(b_data);
    end
  end

  assign addr      = cnt_q;
  assign prod      = prod_q;
  assign prod_load = load_q;
  assign prod_en   = en;

`ifdef POLYMUL_RANGE_CHECK_EN
  localparam logic [16:0] QW = 17'(Q);
  logic err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (state_q == IDLE && start)
      err_q <= 1'b0;
    else if (en && rd_q && (({1'b0, a_data} >= QW) || ({1'b0, b_data} >= QW)))
      err_q <= 1'b1;
  end

  assign range_err = err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule
